// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: takes one fetch address from the PC, issues a single
// read to synchronous instruction memory, waits out the memory latency, holds
// the instruction for decode until it is accepted, and returns a relative
// branch target to the PC when the accepted instruction is a branch.
module instr_fetch_unit #(
  parameter int         ADDR_W    = 16,
  parameter int         DATA_W    = 16,
  parameter int         MEM_LAT   = 2,
  parameter logic [3:0] BR_OPCODE = 4'hB
) (
  input  logic              clk_out,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              br_load,
  output logic [ADDR_W-1:0] br_target,
  output logic [15:0]       fetch_count
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] pc_latched;
  logic              accept;
  logic              handshake;
  logic              is_branch;
  logic              capture;

  // 12-bit instruction offset widened to the address width, keeping its sign.
  function automatic logic signed [ADDR_W-1:0] sext_offset(input logic [11:0] off);
    logic signed [ADDR_W-1:0] wide;
    wide = {{(ADDR_W-12){off[11]}}, off};
    return wide;
  endfunction

  // Relative branch target; the sum wraps modulo 2^ADDR_W in both directions.
  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] base,
                                                      input logic [11:0]       off);
    logic signed [ADDR_W-1:0] delta;
    delta = sext_offset(off);
    return base + $unsigned(delta);
  endfunction

  assign pc_ready  = (state_q == IDLE) && !flush;
  assign accept    = pc_valid && pc_ready;
  // A flush in HOLD beats a simultaneous decode accept.
  assign handshake = (state_q == HOLD) && instr_ready && !flush;
  assign is_branch = (instr_out[DATA_W-1 -: 4] == BR_OPCODE);
  assign capture   = (state_q == WAIT) && (lat_cnt == 4'd0) && !flush;

  // State register.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one fetch in flight, flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (pc_valid) state_d = REQ;
        REQ:     state_d = WAIT;
        WAIT:    if (lat_cnt == 4'd0) state_d = HOLD;
        HOLD:    if (instr_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Memory request, latency countdown, instruction capture and branch return.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_req     <= 1'b0;
      lat_cnt     <= 4'd0;
      pc_latched  <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      br_load     <= 1'b0;
      br_target   <= '0;
      fetch_count <= 16'd0;
    end else begin
      mem_req     <= accept;
      instr_valid <= (state_d == HOLD);
      br_load     <= handshake && is_branch;
      if (accept) begin
        mem_addr   <= pc_in;
        pc_latched <= pc_in;
      end
      if (state_q == REQ) begin
        lat_cnt <= LAT_INIT;
      end else if ((state_q == WAIT) && (lat_cnt != 4'd0)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (capture) begin
        instr_out <= mem_rdata;
      end
      if (handshake) begin
        fetch_count <= fetch_count + 16'd1;
        if (is_branch) begin
          br_target <= branch_target(pc_latched, instr_out[11:0]);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a latency-scheduled memory responder, a
// transaction-level reference model compared every cycle, directed scenarios
// with literal expectations, a randomized phase, and two extra instances built
// with the extreme memory latencies.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam int LAT = 2;

  logic clk_out = 1'b0;
  logic reset;
  always #5 clk_out = ~clk_out;

  logic [15:0] pc_in, mem_addr, mem_rdata, instr_out, br_target, fetch_count;
  logic        pc_valid, pc_ready, flush, mem_req, instr_valid, instr_ready, br_load;

  logic [15:0] l1_pc_in, l1_mem_addr, l1_rdata, l1_instr_out, l1_br_target, l1_fc;
  logic        l1_pc_valid, l1_pc_ready, l1_mem_req, l1_instr_valid, l1_ready, l1_br_load;
  logic [15:0] l15_pc_in, l15_mem_addr, l15_rdata, l15_instr_out, l15_br_target, l15_fc;
  logic        l15_pc_valid, l15_pc_ready, l15_mem_req, l15_instr_valid, l15_ready, l15_br_load;
  logic        side_flush;

  instr_fetch_unit #(.MEM_LAT(LAT)) u_dut (
    .clk_out(clk_out), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_load(br_load), .br_target(br_target), .fetch_count(fetch_count));

  instr_fetch_unit #(.MEM_LAT(1)) u_l1 (
    .clk_out(clk_out), .reset(reset), .pc_in(l1_pc_in), .pc_valid(l1_pc_valid),
    .pc_ready(l1_pc_ready), .flush(side_flush), .mem_addr(l1_mem_addr), .mem_req(l1_mem_req),
    .mem_rdata(l1_rdata), .instr_out(l1_instr_out), .instr_valid(l1_instr_valid),
    .instr_ready(l1_ready), .br_load(l1_br_load), .br_target(l1_br_target), .fetch_count(l1_fc));

  instr_fetch_unit #(.MEM_LAT(15)) u_l15 (
    .clk_out(clk_out), .reset(reset), .pc_in(l15_pc_in), .pc_valid(l15_pc_valid),
    .pc_ready(l15_pc_ready), .flush(side_flush), .mem_addr(l15_mem_addr), .mem_req(l15_mem_req),
    .mem_rdata(l15_rdata), .instr_out(l15_instr_out), .instr_valid(l15_instr_valid),
    .instr_ready(l15_ready), .br_load(l15_br_load), .br_target(l15_br_target), .fetch_count(l15_fc));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: explicit entries, otherwise an address hash
  // that makes every odd address a branch with a varied offset.
  logic [15:0] imem [logic [15:0]];
  function automatic logic [15:0] get_mem(input logic [15:0] a);
    if (imem.exists(a)) return imem[a];
    return {(a[0] ? 4'hB : a[7:4]), a[11:0] ^ 12'h5A3};
  endfunction

  // Memory responder: a request seen in a cycle is answered LAT cycles later
  // for exactly one cycle; every other cycle carries random garbage.
  logic [15:0] slot_d [32];
  bit          slot_v [32];
  int          ncyc = 0;
  initial begin
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk_out);
      if (mem_req === 1'b1) begin
        slot_d[(ncyc + LAT) % 32] = get_mem(mem_addr);
        slot_v[(ncyc + LAT) % 32] = 1'b1;
      end
      if (slot_v[ncyc % 32]) begin
        mem_rdata = slot_d[ncyc % 32];
        slot_v[ncyc % 32] = 1'b0;
      end else begin
        mem_rdata = 16'($urandom);
      end
      ncyc++;
    end
  end

  // Reference model: one transaction at a time, timed by edge counts.
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_tacc = 0;
  int          md;
  logic [15:0] m_addr = 16'h0, m_instr = 16'h0, m_mem_addr = 16'h0;
  logic [15:0] m_fc = 16'h0, m_brt = 16'h0;
  bit          m_brl = 1'b0;

  initial forever begin
    @(posedge clk_out);
    if (reset) begin
      m_busy = 1'b0; m_mem_addr = 16'h0; m_fc = 16'h0; m_brt = 16'h0; m_brl = 1'b0;
    end else begin
      md = m_k - m_tacc;
      m_brl = 1'b0;
      if (flush) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (pc_valid) begin
          m_busy = 1'b1; m_tacc = m_k + 1; m_addr = pc_in; m_mem_addr = pc_in;
          m_instr = get_mem(pc_in);
        end
      end else if (md >= LAT + 1 && instr_ready) begin
        m_busy = 1'b0;
        m_fc = m_fc + 16'd1;
        if (m_instr[15:12] == 4'hB) begin
          m_brl = 1'b1;
          m_brt = m_addr + {{4{m_instr[11]}}, m_instr[11:0]};
        end
      end
    end
    m_k++;
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  int cd;
  initial forever begin
    @(negedge clk_out);
    if (reset === 1'b0) begin
      cd = m_k - m_tacc;
      check("pc_ready", pc_ready, (!m_busy && !flush));
      check("mem_req", mem_req, (m_busy && cd == 0));
      check("mem_addr", mem_addr, m_mem_addr);
      check("instr_valid", instr_valid, (m_busy && cd >= LAT + 1));
      if (m_busy && cd >= LAT + 1) check("instr_out", instr_out, m_instr);
      check("br_load", br_load, m_brl);
      check("br_target", br_target, m_brt);
      check("fetch_count", fetch_count, m_fc);
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < 60) begin
      @(posedge clk_out); #1;
      n++;
    end
    if (n >= 60) check("timeout_instr_valid", 0, 1);
  endtask

  task automatic do_fetch(input logic [15:0] a, output int lat);
    pc_in = a; pc_valid = 1'b1;
    @(posedge clk_out); #1;
    pc_valid = 1'b0;
    wait_valid(lat);
    instr_ready = 1'b1;
    @(posedge clk_out); #1;
    instr_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n, nreq, nv, nb, i, cyc, prev, n1, n15, r;
  logic [15:0] exp_a;

  initial begin
    reset = 1'b1; pc_in = 16'h0; pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    side_flush = 1'b0;
    l1_pc_in = 16'h0; l1_pc_valid = 1'b0; l1_rdata = 16'hC3A5; l1_ready = 1'b0;
    l15_pc_in = 16'h0; l15_pc_valid = 1'b0; l15_rdata = 16'h5A3C; l15_ready = 1'b0;
    repeat (2) @(posedge clk_out);
    #1;
    check("rst_outputs", {mem_req, instr_valid, br_load}, 3'b000);
    check("rst_regs", {mem_addr, fetch_count}, 32'h0);
    check("rst_data", {instr_out, br_target}, 32'h0);
    @(negedge clk_out); #1;
    reset = 1'b0;

    // Basic fetch with decode stalling five cycles.
    imem[16'h0010] = 16'h1234;
    pc_in = 16'h0010; pc_valid = 1'b1;
    @(posedge clk_out); #1;
    pc_valid = 1'b0; nreq = int'(mem_req); n = 0;
    while (instr_valid !== 1'b1 && n < 60) begin
      @(posedge clk_out); #1;
      n++; nreq += int'(mem_req);
    end
    check("t2_latency_edges", n, 3);
    check("t2_mem_req_cycles", nreq, 1);
    check("t2_mem_addr", mem_addr, 16'h0010);
    repeat (5) begin
      check("t2_held_instr", instr_out, 16'h1234);
      check("t2_held_valid", instr_valid, 1);
      @(posedge clk_out); #1;
    end
    instr_ready = 1'b1;
    @(posedge clk_out); #1;
    instr_ready = 1'b0;
    check("t2_fetch_count", fetch_count, 16'd1);
    check("t2_valid_dropped", instr_valid, 0);
    check("t2_no_br_load", br_load, 0);

    // Branch targets, including wrap past 16'hFFFF, and a non-branch.
    imem[16'h0100] = 16'hBFFE;
    do_fetch(16'h0100, n);
    check("t3_br_load", br_load, 1);
    check("t3_br_target", br_target, 16'h00FE);
    @(posedge clk_out); #1;
    check("t3_br_load_one_cycle", br_load, 0);
    check("t3_br_target_held", br_target, 16'h00FE);
    imem[16'hFFFF] = 16'hB002;
    do_fetch(16'hFFFF, n);
    check("t3_wrap_br_load", br_load, 1);
    check("t3_wrap_br_target", br_target, 16'h0001);
    imem[16'h0300] = 16'h7FFF;
    do_fetch(16'h0300, n);
    check("t3_nonbranch_br_load", br_load, 0);
    check("t3_nonbranch_target_kept", br_target, 16'h0001);
    check("t3_fetch_count", fetch_count, 16'd4);

    // Flush in WAIT, then flush racing a branch accept in HOLD.
    imem[16'h0200] = 16'hB010;
    pc_in = 16'h0200; pc_valid = 1'b1;
    @(posedge clk_out); #1;
    pc_valid = 1'b0;
    @(posedge clk_out); #1;
    flush = 1'b1;
    @(posedge clk_out); #1;
    flush = 1'b0; instr_ready = 1'b1; nv = 0; nb = 0;
    repeat (8) begin
      @(posedge clk_out); #1;
      nv += int'(instr_valid); nb += int'(br_load);
    end
    instr_ready = 1'b0;
    check("t4_flush_wait_valid", nv, 0);
    check("t4_flush_wait_br_load", nb, 0);
    check("t4_flush_wait_count", fetch_count, 16'd4);
    pc_in = 16'h0200; pc_valid = 1'b1;
    @(posedge clk_out); #1;
    pc_valid = 1'b0;
    wait_valid(n);
    flush = 1'b1; instr_ready = 1'b1;
    @(posedge clk_out); #1;
    flush = 1'b0; instr_ready = 1'b0;
    check("t4_flush_hold_valid", instr_valid, 0);
    check("t4_flush_hold_br_load", br_load, 0);
    @(posedge clk_out); #1;
    check("t4_flush_hold_br_load_late", br_load, 0);
    check("t4_flush_hold_count", fetch_count, 16'd4);
    flush = 1'b1; pc_valid = 1'b1; pc_in = 16'h0500;
    #1;
    check("t4_flush_blocks_ready", pc_ready, 0);
    @(posedge clk_out); #1;
    flush = 1'b0; pc_valid = 1'b0;
    check("t4_flush_no_accept", mem_req, 0);

    // Asynchronous reset in the middle of a branch fetch.
    pc_in = 16'h0200; pc_valid = 1'b1;
    @(posedge clk_out); #1;
    pc_valid = 1'b0;
    @(posedge clk_out); #3;
    reset = 1'b1;
    #1;
    check("t1_async_outputs", {mem_req, instr_valid, br_load}, 3'b000);
    check("t1_async_regs", {mem_addr, fetch_count}, 32'h0);
    check("t1_async_data", {instr_out, br_target}, 32'h0);
    check("t1_pc_ready_in_reset", pc_ready, 1);
    repeat (2) @(posedge clk_out);
    @(negedge clk_out); #1;
    reset = 1'b0;
    check("t1_pc_ready_after", pc_ready, 1);
    instr_ready = 1'b1; nv = 0; nb = 0;
    repeat (8) begin
      @(posedge clk_out); #1;
      nv += int'(instr_valid); nb += int'(br_load);
    end
    instr_ready = 1'b0;
    check("t1_no_valid_after", nv, 0);
    check("t1_no_br_load_after", nb, 0);

    // Continuous pc_valid with decode always ready.
    pc_valid = 1'b1; instr_ready = 1'b1; pc_in = 16'h4000; i = 0; prev = 0; cyc = 0;
    while (i < 6 && cyc < 100) begin
      @(posedge clk_out); #1;
      cyc++;
      if (mem_req) begin
        exp_a = 16'h4000 + 16'(i * 7);
        check("t5_addr_order", mem_addr, exp_a);
        if (i > 0) check("t5_spacing", cyc - prev, LAT + 3);
        prev = cyc;
        i++;
        pc_in = 16'h4000 + 16'(i * 7);
      end
    end
    check("t5_fetches_seen", i, 6);
    pc_valid = 1'b0;
    repeat (8) @(posedge clk_out);
    #1;
    instr_ready = 1'b0;
    check("t5_fetch_count", fetch_count, 16'd6);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_out); #1;
      r = int'($urandom_range(0, 3));
      if (r == 0)      pc_in = 16'hFFF0 + 16'($urandom_range(0, 15));
      else if (r == 1) pc_in = 16'($urandom_range(0, 15));
      else             pc_in = 16'($urandom);
      pc_valid    = ($urandom_range(0, 1) == 1);
      flush       = ($urandom_range(0, 15) == 0);
      instr_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk_out); #1;
    pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0;

    // Extreme latency builds; the MEM_LAT=1 counter is preloaded to wrap.
    force u_l1.fetch_count = 16'hFFFF;
    #1;
    release u_l1.fetch_count;
    check("t6_l1_pc_ready", l1_pc_ready, 1);
    check("t6_l15_pc_ready", l15_pc_ready, 1);
    l1_pc_in = 16'h1111; l15_pc_in = 16'h2222;
    l1_pc_valid = 1'b1; l15_pc_valid = 1'b1;
    @(posedge clk_out); #1;
    l1_pc_valid = 1'b0; l15_pc_valid = 1'b0;
    n1 = 0; n15 = 0;
    nreq = int'(l1_mem_req) + int'(l15_mem_req);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk_out); #1;
      nreq += int'(l1_mem_req) + int'(l15_mem_req);
      if (l1_instr_valid && n1 == 0) n1 = e;
      if (l15_instr_valid && n15 == 0) n15 = e;
    end
    check("t6_lat1_edges", n1, 2);
    check("t6_lat15_edges", n15, 16);
    check("t6_mem_req_total", nreq, 2);
    check("t6_l1_instr", l1_instr_out, 16'hC3A5);
    check("t6_l15_instr", l15_instr_out, 16'h5A3C);
    check("t6_l1_addr", l1_mem_addr, 16'h1111);
    check("t6_l15_addr", l15_mem_addr, 16'h2222);
    l1_ready = 1'b1; l15_ready = 1'b1;
    @(posedge clk_out); #1;
    l1_ready = 1'b0; l15_ready = 1'b0;
    check("t6_count_wrap", l1_fc, 16'h0000);
    check("t6_l15_count", l15_fc, 16'd1);
    check("t6_no_branch", {l1_br_load, l15_br_load}, 2'b00);
    check("t6_targets_untouched", {l1_br_target, l15_br_target}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
